// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, RX FSM states
// and an elaboration-time log2 helper used for counter and pointer widths.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with occupancy count; a write to a full FIFO
// is accepted when a read retires the head in the same cycle.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [clog2(DEPTH):0]  count,
  output logic [clog2(DEPTH):0]  count_next
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_comb begin
    count_next = count;
    if (wr_ok && !rd_ok)
      count_next = count + 1'b1;
    else if (rd_ok && !wr_ok)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  // Storage is not reset, so the head is forced to zero while nothing is held.
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with selectable parity, start-glitch rejection and framing
// check, feeding a tagged FWFT FIFO with CTS flow control and sticky overrun.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CTS_MARGIN   = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        serial_in,
  input  logic [1:0]                  parity_mode,
  input  logic                        rd_en,
  input  logic                        clear_overrun,
  output logic [DATA_BITS-1:0]        rd_data,
  output logic                        rd_parity_err,
  output logic                        rd_frame_err,
  output logic                        empty,
  output logic                        full,
  output logic [clog2(FIFO_DEPTH):0]  count,
  output logic                        cts,
  output logic                        overrun
);

  localparam int CNTW = clog2(CLKS_PER_BIT);
  localparam int BITW = clog2(DATA_BITS + 1);
  localparam int CW   = clog2(FIFO_DEPTH) + 1;

  localparam logic [CNTW-1:0] HALF_BIT  = CNTW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNTW-1:0] FULL_BIT  = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [BITW-1:0] LAST_BIT  = BITW'(DATA_BITS - 1);
  localparam logic [CW-1:0]   CTS_LIMIT = CW'(FIFO_DEPTH - CTS_MARGIN);

  rx_state_t             state;
  logic                  rx_meta;
  logic                  rx_s;
  logic                  rx_prev;
  logic [1:0]            settle;
  logic [CNTW-1:0]       cnt;
  logic [BITW-1:0]       bit_idx;
  logic [DATA_BITS-1:0]  shift;
  logic [1:0]            mode;
  logic                  perr;
  logic                  tick;
  logic                  fall;
  logic                  par_on;
  logic                  push;
  logic                  drop;
  logic [CW-1:0]         count_next;
  logic [DATA_BITS+1:0]  wr_word;
  logic [DATA_BITS+1:0]  head_word;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      settle  <= '0;
    end else begin
      rx_meta <= serial_in;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      if (settle != 2'd3) settle <= settle + 1'b1;
    end
  end

  // Edges are only trusted once all three flops hold real line samples, so a
  // line that is already low when reset releases cannot fake a start bit.
  assign fall   = (settle == 2'd3) && rx_prev && !rx_s;
  assign tick   = (cnt == '0);
  assign par_on = (mode == PAR_EVEN) || (mode == PAR_ODD);
  assign push   = (state == ST_STOP) && tick;
  assign drop   = push && full && !rd_en;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      mode    <= PAR_NONE;
      perr    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state <= ST_START;
            cnt   <= HALF_BIT;
            mode  <= parity_mode;
            perr  <= 1'b0;
          end
        end
        ST_START: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            state <= ST_IDLE;
          end else begin
            state   <= ST_DATA;
            cnt     <= FULL_BIT;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt     <= FULL_BIT;
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) state <= par_on ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt   <= FULL_BIT;
            perr  <= (^shift) ^ rx_s ^ (mode == PAR_ODD);
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (!tick) cnt <= cnt - 1'b1;
          else       state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
      cts     <= 1'b1;
    end else begin
      if (drop)               overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
      cts <= (count_next < CTS_LIMIT);
    end
  end

  assign wr_word = {!rx_s, perr, shift};

  sync_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (push),
    .wr_data    (wr_word),
    .rd_en      (rd_en),
    .rd_data    (head_word),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .count_next (count_next)
  );

  assign rd_frame_err  = head_word[DATA_BITS+1];
  assign rd_parity_err = head_word[DATA_BITS];
  assign rd_data       = head_word[DATA_BITS-1:0];

endmodule
